// File: rtl/result_ram_writer.sv
// result_ram_writer
//
// Drains the 32-bit result FIFO, packs four results into one 128-bit word
// (lane0 = [31:0] holds the earliest result) and writes the words into the
// result RAM that PCIe reads back. A batch is bounded by expected_cnt, which
// is latched on batch_start. A partial final word is zero-padded and flushed,
// then result_write_done pulses for one cycle.
//
// Build option: RESULT_TIMEOUT_EN adds an idle watchdog. If RUN goes
// TIMEOUT_CYC cycles without a result, timeout_err is set and the batch is
// closed (partial flush if needed, then the done pulse). Without the macro,
// timeout_err is tied low and RUN waits indefinitely.
//
// Ports
//   sys_clk, sys_rst      clock, asynchronous active-high reset
//   batch_start           one-cycle start pulse (ignored while busy)
//   expected_cnt          results in the batch, sampled on an accepted start
//   result_fifo_empty     FIFO empty flag
//   result_fifo_rdat      FIFO data, valid the cycle after rden
//   result_fifo_rden      FIFO read strobe
//   result_ram_wren       RAM write enable
//   result_ram_waddr      RAM word address
//   result_ram_wdat       packed 128-bit word
//   result_cnt            results received in the current batch
//   busy                  high outside IDLE, through the done pulse
//   result_write_done     one-cycle batch done pulse
//   overflow_err          sticky: write address wrapped during the batch
//   timeout_err           sticky: watchdog fired (RESULT_TIMEOUT_EN only)
//
// state | meaning
// IDLE  | waiting for batch_start; FIFO is never read
// RUN   | reading the FIFO and packing lanes; full words are written
// FLUSH | writing the zero-padded partial final word
// DONE  | batch closed; launches the one-cycle done pulse

module result_ram_writer #(
    parameter int ADDR_W      = 14,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              batch_start,
    input  logic [CNT_W-1:0]  expected_cnt,
    input  logic              result_fifo_empty,
    input  logic [31:0]       result_fifo_rdat,
    output logic              result_fifo_rden,
    output logic              result_ram_wren,
    output logic [ADDR_W-1:0] result_ram_waddr,
    output logic [127:0]      result_ram_wdat,
    output logic [CNT_W-1:0]  result_cnt,
    output logic              busy,
    output logic              result_write_done,
    output logic              overflow_err,
    output logic              timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  exp_cnt;
    logic [CNT_W-1:0]  issued_cnt;
    logic [1:0]        lane;
    logic [31:0]       lane0_q;
    logic [31:0]       lane1_q;
    logic [31:0]       lane2_q;
    logic              rd_vld;
    logic [ADDR_W-1:0] waddr_cnt;
    logic              start_ok;
    logic              last_rslt;
    logic              wdog_hit;
    logic [127:0]      flush_word;

    // The done cycle still counts as busy so a start that lands on the done
    // pulse is ignored rather than racing the closing batch.
    assign busy      = (state != S_IDLE) || result_write_done;
    assign start_ok  = batch_start && !busy;
    assign last_rslt = rd_vld && ((result_cnt + CNT_W'(1)) == exp_cnt);

    // Reads stop once every expected result has been requested, so the FIFO
    // is never over-read. A firing watchdog also blocks a new read so no data
    // is left in flight when RUN is abandoned.
    assign result_fifo_rden = (state == S_RUN) && !result_fifo_empty &&
                              (issued_cnt != exp_cnt) && !wdog_hit;

`ifdef RESULT_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC);

    // Down-counter reloaded on every received result; terminal count 0
    // means TIMEOUT_CYC consecutive RUN cycles passed without one.
    logic [WD_W-1:0] wdog;

    assign wdog_hit = (state == S_RUN) && !rd_vld && (wdog == '0);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else if (start_ok) begin
            wdog        <= WD_LOAD;
            timeout_err <= 1'b0;
        end else if (state == S_RUN) begin
            if (rd_vld) begin
                wdog <= WD_LOAD;
            end else if (wdog_hit) begin
                timeout_err <= 1'b1;
            end else begin
                wdog <= wdog - 1'b1;
            end
        end
    end
`else
    assign wdog_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = (expected_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_rslt) begin
                    // lane 3 here means this result completes the word
                    state_nxt = (lane == 2'd3) ? S_DONE : S_FLUSH;
                end else if (wdog_hit) begin
                    state_nxt = (lane != 2'd0) ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // lane holds the number of lanes already filled; unfilled lanes read 0.
    always_comb begin
        flush_word = '0;
        if (lane >= 2'd1) flush_word[31:0]  = lane0_q;
        if (lane >= 2'd2) flush_word[63:32] = lane1_q;
        if (lane >= 2'd3) flush_word[95:64] = lane2_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            exp_cnt           <= '0;
            issued_cnt        <= '0;
            result_cnt        <= '0;
            lane              <= '0;
            lane0_q           <= '0;
            lane1_q           <= '0;
            lane2_q           <= '0;
            rd_vld            <= 1'b0;
            waddr_cnt         <= '0;
            result_ram_wren   <= 1'b0;
            result_ram_waddr  <= '0;
            result_ram_wdat   <= '0;
            result_write_done <= 1'b0;
            overflow_err      <= 1'b0;
        end else begin
            rd_vld            <= result_fifo_rden;
            result_ram_wren   <= 1'b0;
            result_write_done <= (state == S_DONE);

            if (result_fifo_rden) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
            end

            if (start_ok) begin
                exp_cnt      <= expected_cnt;
                issued_cnt   <= '0;
                result_cnt   <= '0;
                waddr_cnt    <= '0;
                lane         <= '0;
                overflow_err <= 1'b0;
            end

            if ((state == S_RUN) && rd_vld) begin
                result_cnt <= result_cnt + CNT_W'(1);
                lane       <= lane + 2'd1;
                case (lane)
                    2'd0: lane0_q <= result_fifo_rdat;
                    2'd1: lane1_q <= result_fifo_rdat;
                    2'd2: lane2_q <= result_fifo_rdat;
                    default: begin
                        result_ram_wdat  <= {result_fifo_rdat, lane2_q, lane1_q, lane0_q};
                        result_ram_wren  <= 1'b1;
                        result_ram_waddr <= waddr_cnt;
                        waddr_cnt        <= waddr_cnt + 1'b1;
                        if (waddr_cnt == '1) begin
                            overflow_err <= 1'b1;
                        end
                    end
                endcase
            end

            if (state == S_FLUSH) begin
                result_ram_wdat  <= flush_word;
                result_ram_wren  <= 1'b1;
                result_ram_waddr <= waddr_cnt;
                waddr_cnt        <= waddr_cnt + 1'b1;
                lane             <= '0;
                if (waddr_cnt == '1) begin
                    overflow_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_ram_writer.sv
// Testbench for result_ram_writer. A small FIFO model feeds the DUT; every
// value pushed into the FIFO is also appended to a model queue, and each
// accepted batch turns the next expected_cnt model values into expected RAM
// writes (scoreboard). Writes are popped and compared as the DUT makes them.

module tb_result_ram_writer;

    localparam int ADDR_W      = 2;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT_CYC = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              batch_start = 1'b0;
    logic [CNT_W-1:0]  expected_cnt = '0;
    logic              result_fifo_empty;
    logic [31:0]       result_fifo_rdat = '0;
    logic              result_fifo_rden;
    logic              result_ram_wren;
    logic [ADDR_W-1:0] result_ram_waddr;
    logic [127:0]      result_ram_wdat;
    logic [CNT_W-1:0]  result_cnt;
    logic              busy;
    logic              result_write_done;
    logic              overflow_err;
    logic              timeout_err;

    result_ram_writer #(
        .ADDR_W      (ADDR_W),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .batch_start       (batch_start),
        .expected_cnt      (expected_cnt),
        .result_fifo_empty (result_fifo_empty),
        .result_fifo_rdat  (result_fifo_rdat),
        .result_fifo_rden  (result_fifo_rden),
        .result_ram_wren   (result_ram_wren),
        .result_ram_waddr  (result_ram_waddr),
        .result_ram_wdat   (result_ram_wdat),
        .result_cnt        (result_cnt),
        .busy              (busy),
        .result_write_done (result_write_done),
        .overflow_err      (overflow_err),
        .timeout_err       (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- FIFO model ----------------
    logic [31:0] fifo_mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        stall  = 1'b0;

    assign result_fifo_empty = (rd_ptr == wr_ptr) || stall;

    always @(posedge sys_clk) begin
        if (result_fifo_rden && (rd_ptr != wr_ptr)) begin
            result_fifo_rdat <= fifo_mem[rd_ptr % 256];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [127:0]      d;
    } wr_t;

    wr_t         exp_q [$];
    logic [31:0] mq [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
        end
    endtask

    // ---------------- monitor ----------------
    int   rden_cnt = 0;
    int   wren_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_wr_cyc = 0;
    int   start_cyc = 0;
    logic lat_chk = 1'b0;
    int   rden_cyc_q [$];
    wr_t  mon_e;
    int   mon_c;

    always @(negedge sys_clk) begin
        if (result_fifo_rden) begin
            rden_cnt++;
            if (result_fifo_empty) check("rden_while_empty", 1, 0);
            if (!busy) check("rden_while_idle", 1, 0);
            if (lat_chk) rden_cyc_q.push_back(cyc);
        end
        if (result_ram_wren) begin
            wren_cnt++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", result_ram_waddr, mon_e.a);
                check("wr_data", result_ram_wdat, mon_e.d);
            end
            if (lat_chk) begin
                if (rden_cyc_q.size() >= 4) begin
                    repeat (3) void'(rden_cyc_q.pop_front());
                    mon_c = rden_cyc_q.pop_front();
                    check("rden_to_wren_latency", cyc - mon_c, 2);
                end else begin
                    check("reads_before_write", rden_cyc_q.size(), 4);
                end
            end
        end
        if (result_write_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic model_add(input logic [31:0] v);
        mq.push_back(v);
    endtask

    task automatic fifo_add(input logic [31:0] v);
        fifo_mem[wr_ptr % 256] = v;
        wr_ptr++;
    endtask

    task automatic push(input logic [31:0] v);
        model_add(v);
        fifo_add(v);
    endtask

    // Consumes nvals model values and queues the first nwr expected words.
    task automatic start_batch(input int cnt, input int nvals, input int nwr);
        logic [31:0] vals [$];
        wr_t         e;
        for (int i = 0; i < nvals; i++) vals.push_back(mq.pop_front());
        for (int w = 0; w < nwr; w++) begin
            e.a = ADDR_W'(w % (1 << ADDR_W));
            e.d = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * w + l < nvals) e.d[32 * l +: 32] = vals[4 * w + l];
            end
            exp_q.push_back(e);
        end
        expected_cnt = CNT_W'(cnt);
        batch_start  = 1'b1;
        start_cyc    = cyc;
        tick(1);
        batch_start  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int d0 = done_cnt;
        for (int i = 0; (i < max_cyc) && (done_cnt == d0); i++) tick(1);
        if (done_cnt == d0) check("done_wait_expired", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "simulation stopped");
    end

    // ---------------- tests ----------------
    initial begin
        int r0, w0, d0;

        tick(3);
        check("rst_busy", busy, 0);
        check("rst_wren", result_ram_wren, 0);
        check("rst_done", result_write_done, 0);
        check("rst_cnt", result_cnt, 0);
        check("rst_wdat", result_ram_wdat, 0);
        check("rst_ovf", overflow_err, 0);
        sys_rst = 1'b0;
        tick(2);

        // batch of 8, FIFO preloaded, idle with non-empty FIFO first
        for (int v = 1; v <= 8; v++) push(32'(v));
        tick(4);
        check("idle_no_read", rden_cnt, 0);
        r0 = rden_cnt; w0 = wren_cnt; d0 = done_cnt;
        lat_chk = 1'b1;
        start_batch(8, 8, 2);
        wait_done(100);
        lat_chk = 1'b0;
        check("b8_busy_after_done", busy, 0);
        check("b8_result_cnt", result_cnt, 8);
        check("b8_reads", rden_cnt - r0, 8);
        check("b8_writes", wren_cnt - w0, 2);
        check("b8_done_pulses", done_cnt - d0, 1);
        check("b8_done_after_write", done_cyc - last_wr_cyc, 1);

        // batch of 6 -> padded flush
        for (int v = 1; v <= 6; v++) push(32'hA000_0000 + 32'(v));
        r0 = rden_cnt; w0 = wren_cnt; d0 = done_cnt;
        start_batch(6, 6, 2);
        wait_done(100);
        check("b6_result_cnt", result_cnt, 6);
        check("b6_writes", wren_cnt - w0, 2);
        check("b6_done_pulses", done_cnt - d0, 1);
        check("b6_done_after_flush", done_cyc - last_wr_cyc, 1);

        // expected_cnt = 0
        r0 = rden_cnt; w0 = wren_cnt; d0 = done_cnt;
        start_batch(0, 0, 0);
        wait_done(20);
        check("b0_reads", rden_cnt - r0, 0);
        check("b0_writes", wren_cnt - w0, 0);
        check("b0_done_delay", done_cyc - start_cyc, 2);
        check("b0_busy_after_done", busy, 0);

        // batch of 4 with toggling empty; 6 values available; restart ignored
        for (int v = 1; v <= 6; v++) push(32'hB000_0000 + 32'(v));
        r0 = rden_cnt; w0 = wren_cnt; d0 = done_cnt;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    stall = ~stall;
                    tick(1);
                end
                stall = 1'b0;
            end
            begin
                start_batch(4, 4, 1);
                tick(3);
                expected_cnt = CNT_W'(9);
                batch_start  = 1'b1;
                tick(1);
                batch_start  = 1'b0;
                wait_done(100);
            end
        join
        tick(5);
        check("stall_reads", rden_cnt - r0, 4);
        check("stall_writes", wren_cnt - w0, 1);
        check("stall_done_pulses", done_cnt - d0, 1);
        check("stall_result_cnt", result_cnt, 4);
        check("stall_busy", busy, 0);

        // batch of 20 with a 4-word address space: 0,1,2,3,0
        for (int v = 1; v <= 18; v++) push(32'hC000_0000 + 32'(v));
        w0 = wren_cnt;
        start_batch(20, 20, 5);
        wait_done(200);
        check("wrap_writes", wren_cnt - w0, 5);
        check("wrap_result_cnt", result_cnt, 20);
        check("wrap_overflow", overflow_err, 1);

`ifdef RESULT_TIMEOUT_EN
        // only 3 of 4 results arrive; watchdog closes the batch
        for (int v = 1; v <= 3; v++) push(32'hD000_0000 + 32'(v));
        w0 = wren_cnt; d0 = done_cnt;
        start_batch(4, 3, 1);
        check("ovf_cleared_on_start", overflow_err, 0);
        tick(12);
        check("tmo_not_yet", timeout_err, 0);
        check("tmo_busy_waiting", busy, 1);
        wait_done(100);
        check("tmo_err", timeout_err, 1);
        check("tmo_writes", wren_cnt - w0, 1);
        check("tmo_done_pulses", done_cnt - d0, 1);
        check("tmo_result_cnt", result_cnt, 3);
`else
        // FIFO runs dry for a long stretch; lanes are held until data resumes
        for (int v = 1; v <= 3; v++) push(32'hD000_0000 + 32'(v));
        model_add(32'hD000_0004);
        w0 = wren_cnt; d0 = done_cnt;
        start_batch(4, 4, 1);
        check("ovf_cleared_on_start", overflow_err, 0);
        tick(100);
        check("dry_busy", busy, 1);
        check("dry_result_cnt", result_cnt, 3);
        check("dry_no_write", wren_cnt - w0, 0);
        check("dry_no_done", done_cnt - d0, 0);
        check("dry_no_timeout", timeout_err, 0);
        fifo_add(32'hD000_0004);
        wait_done(50);
        check("dry_writes", wren_cnt - w0, 1);
        check("dry_result_cnt_end", result_cnt, 4);
`endif

        // reset in the middle of a batch
        for (int v = 1; v <= 5; v++) push(32'hE000_0000 + 32'(v));
        start_batch(8, 5, 1);
        for (int i = 0; (i < 50) && (result_cnt != 16'd5); i++) tick(1);
        check("rst_mid_cnt_reached", result_cnt, 5);
        tick(3);
        d0 = done_cnt;
        sys_rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rden", result_fifo_rden, 0);
        check("rst_mid_wren", result_ram_wren, 0);
        check("rst_mid_waddr", result_ram_waddr, 0);
        check("rst_mid_wdat", result_ram_wdat, 0);
        check("rst_mid_cnt", result_cnt, 0);
        check("rst_mid_ovf", overflow_err, 0);
        check("rst_mid_tmo", timeout_err, 0);
        tick(1);
        sys_rst = 1'b0;
        tick(10);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_idle", busy, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/result_ram_writer.md
Name: result_ram_writer

Overview:
Downstream stage of matrix_6. Drains the 32-bit result FIFO, packs four results into one 128-bit word, and writes the words into the 128-bit result RAM that PCIe reads back. Counts results against a host-programmed batch size, pads and flushes a partial final word, then pulses a done strobe to the PCIe side.

Parameters:
ADDR_W, 14, result RAM word-address width
CNT_W, 16, width of the result counters and expected_cnt
TIMEOUT_CYC, 4096, idle-cycle limit for the optional watchdog

Ports:
sys_clk  in  1  system clock; all logic on posedge
sys_rst  in  1  asynchronous reset, active-high
batch_start  in  1  one-cycle pulse that starts a batch; driven from pcie_write_done
expected_cnt  in  CNT_W  number of 32-bit results in the batch; sampled on batch_start
result_fifo_empty  in  1  result FIFO empty flag
result_fifo_rdat  in  32  FIFO read data; valid the cycle after rden
result_fifo_rden  out  1  FIFO read strobe
result_ram_wren  out  1  RAM write enable
result_ram_waddr  out  ADDR_W  RAM word address
result_ram_wdat  out  128  packed word; lane0=[31:0] holds the earliest result
result_cnt  out  CNT_W  results received in the current batch
busy  out  1  high outside IDLE
result_write_done  out  1  one-cycle done pulse
overflow_err  out  1  sticky: address wrapped during the batch
timeout_err  out  1  sticky: watchdog fired (RESULT_TIMEOUT_EN only)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; lane index 0; issued/received counters 0.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - On batch_start: latch expected_cnt; clear result_cnt, waddr, lane, overflow_err and timeout_err.
  - expected_cnt=0 goes straight to DONE; otherwise go to RUN.
  - The FIFO is never read in IDLE, even when it is non-empty.
- RUN read side:
  - rden = ~result_fifo_empty && (issued < expected).
  - rd_vld is rden delayed by one cycle.
- RUN capture side:
  - On each rd_vld cycle, rdat is stored into the current lane, lane increments and result_cnt increments.
  - When the lane being filled is 3: wdat is registered with the 3 held lanes plus the incoming data, and wren=1 the next cycle at the current waddr.
  - waddr increments after each write.
- RUN exit:
  - When received==expected and that result completed a word (lane 3), go to DONE; FLUSH is skipped.
  - If lane≠0 after the last result, go to FLUSH.
- FLUSH:
  - One cycle: write the partial word, with unused lanes forced to 32'h0.
  - wren=1, waddr increments, lane clears; then go to DONE.
- DONE: result_write_done=1 for exactly one cycle; busy drops the next cycle; return to IDLE.
- Latency: 2 cycles from rden to wren for a completing result.
- Address wrap: a write at waddr=2^ADDR_W-1 wraps the next address to 0 and sets overflow_err. overflow_err holds until the next accepted batch_start.
- A batch_start while busy is ignored, and expected_cnt is not resampled.
- Empty FIFO mid-batch: rden stalls and lane contents are held indefinitely. The watchdog applies only when RESULT_TIMEOUT_EN is defined.
- Asynchronous reset mid-batch: immediate return to IDLE with all outputs 0. Partially packed lanes are discarded and no done pulse is produced.
- Counter arithmetic: CNT_W unsigned. issued never exceeds expected_cnt, so no extra FIFO reads are made.

Optional Feature:
Macro RESULT_TIMEOUT_EN.
- Defined: an idle counter clears on every rd_vld and on entering RUN, and increments in each RUN cycle without rd_vld. On reaching TIMEOUT_CYC:
  - set timeout_err;
  - go to FLUSH if lane≠0, else to DONE;
  - result_write_done still pulses.
- Not defined: no idle counter, timeout_err is tied to 0, and RUN waits indefinitely.

Test Plan:
- Batch of 8 with the FIFO preloaded 32'h1..32'h8 -> two writes: addr0 = 128'h00000004_00000003_00000002_00000001, addr1 = 128'h..8_7_6_5. result_cnt=8, one done pulse, no FLUSH cycle.
- Batch of 6 (results A1..A6) -> addr1 = {32'h0, 32'h0, A6, A5}. Done pulses 1 cycle after the FLUSH write.
- expected_cnt=0 -> no rden and no wren; done pulses 2 cycles after batch_start.
- FIFO empty toggling every other cycle with batch 4 -> rden only when non-empty; exactly 4 reads and 1 write. A second batch_start mid-run is ignored.
- ADDR_W=2 with batch 20 -> 5 writes to addresses 0,1,2,3,0; overflow_err=1 after the 5th write.
- With RESULT_TIMEOUT_EN and TIMEOUT_CYC=16: batch 4 with only 3 results supplied -> timeout_err=1 after 16 idle cycles, then partial write {32'h0, r3, r2, r1} and done pulse. Asserting sys_rst mid-batch clears all outputs in the same cycle.
